// File: rtl/adder_5_bit_sequencer_pkg.sv
// rtl/adder_5_bit_sequencer_pkg.sv - shared calculator constants and state encoding
package adder_5_bit_sequencer_pkg;

   localparam int CALC_WIDTH = 5;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/adder_5_bit_sequencer_adder.sv
// rtl/adder_5_bit_sequencer_adder.sv - ripple-carry adder shared by all calculator ops
module adder_5_bit_sequencer_adder #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] c;

   assign c[0] = cin;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
   end

   assign cout = c[WIDTH];

endmodule

// File: rtl/adder_5_bit_sequencer.sv
// rtl/adder_5_bit_sequencer.sv - time-shares one ripple adder for ADD, SUB and shift-add MUL
module adder_5_bit_sequencer
   import adder_5_bit_sequencer_pkg::*;
#(
   parameter int WIDTH     = CALC_WIDTH,
   parameter int MUL_STEPS = WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 carry,
   output logic                 err
);

   if (WIDTH != CALC_WIDTH) begin : g_bad_width
      $error("adder_5_bit_sequencer supports only WIDTH=5");
   end

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       a_q, a_d;
   logic [WIDTH-1:0]       b_q, b_d;
   logic [1:0]             op_q, op_d;
   logic [WIDTH-1:0]       acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0]       acc_lo_q, acc_lo_d;
   logic [MUL_STEPS-1:0]   step_q, step_d;
   logic [2*WIDTH-1:0]     result_q, result_d;
   logic                   carry_q, carry_d;
   logic                   err_q, err_d;

   logic [WIDTH-1:0]       add_a, add_b, add_sum;
   logic                   add_cin, add_cout;

   adder_5_bit_sequencer_adder #(.WIDTH(WIDTH)) u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      step_d   = step_q;
      result_d = result_q;
      carry_d  = carry_q;
      err_d    = err_q;
      add_a    = a_q;
      add_b    = b_q;
      add_cin  = 1'b0;

      case (state_q)
         ST_EXEC: begin
            if (op_q == OP_SUB) begin
               add_b   = ~b_q;
               add_cin = 1'b1;
               result_d = {{WIDTH{1'b0}}, add_sum};
            end else begin
               result_d = {{(WIDTH-1){1'b0}}, add_cout, add_sum};
            end
            carry_d = add_cout;
            err_d   = 1'b0;
            state_d = ST_DONE;
         end
         ST_MUL: begin
            add_a = acc_hi_q;
            add_b = acc_lo_q[0] ? a_q : '0;
            // step_q is a thermometer code; its top bit marks all passes done
            if (step_q[MUL_STEPS-1]) begin
               result_d = {acc_hi_q, acc_lo_q};
               carry_d  = 1'b0;
               err_d    = 1'b0;
               state_d  = ST_DONE;
            end else begin
               {acc_hi_d, acc_lo_d} = {add_cout, add_sum, acc_lo_q[WIDTH-1:1]};
               step_d = {step_q[MUL_STEPS-2:0], 1'b1};
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
         a_d  = a;
         b_d  = b;
         op_d = op;
         case (op)
            OP_ADD, OP_SUB: state_d = ST_EXEC;
            OP_MUL: begin
               acc_hi_d = '0;
               acc_lo_d = b;
               step_d   = '0;
               state_d  = ST_MUL;
            end
            default: begin
               result_d = '0;
               carry_d  = 1'b0;
               err_d    = 1'b1;
               state_d  = ST_DONE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         step_q   <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         step_q   <= step_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         err_q    <= err_d;
      end
   end

   assign busy   = (state_q == ST_EXEC) || (state_q == ST_MUL);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign carry  = carry_q;
   assign err    = err_q;

endmodule

// File: tb/tb_adder_5_bit_sequencer.sv
// tb/tb_adder_5_bit_sequencer.sv - scoreboard bench for the adder sequencer
module tb_adder_5_bit_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] op;
   logic [4:0] a, b;
   logic       busy, done, carry, err;
   logic [9:0] result;

   typedef struct {
      logic [9:0] res;
      logic       c;
      logic       e;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   adder_5_bit_sequencer dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .carry  (carry),
      .err    (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic exp_t model(input logic [1:0] o, input int x, input int y, input int c0);
      exp_t r;
      int   lat;
      r.res = '0; r.c = 1'b0; r.e = 1'b0;
      case (o)
         2'b00: begin r.res = 10'(x + y); r.c = (x + y) > 31; lat = 1; end
         2'b01: begin r.res = 10'((x - y + 32) % 32); r.c = (x >= y); lat = 1; end
         2'b10: begin r.res = 10'(x * y); lat = 6; end
         default: begin r.e = 1'b1; lat = 0; end
      endcase
      r.cyc = c0 + 1 + lat;
      return r;
   endfunction

   task automatic issue(input logic [1:0] o, input int x, input int y);
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("issue_wait_timeout", 1, 0);
      start = 1'b1; op = o; a = 5'(x); b = 5'(y);
      exp_q.push_back(model(o, x, y, cyc));
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("result", int'(result), int'(e.res));
               chk("carry", int'(carry), int'(e.c));
               chk("err", int'(err), int'(e.e));
               chk("done_latency", cyc, e.cyc);
            end
         end
      end
   end

   initial begin : stim
      int n;
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_carry", int'(carry), 0);
      chk("rst_err", int'(err), 0);
      rst = 1'b0;
      @(negedge clk);

      // ADD with busy-width observation
      issue(2'b00, 13, 22);
      chk("add_busy_edge0", int'(busy), 1);
      chk("add_done_edge0", int'(done), 0);
      @(negedge clk);
      chk("add_busy_edge1", int'(busy), 0);
      chk("add_done_edge1", int'(done), 1);
      @(negedge clk);

      issue(2'b01, 9, 12);
      issue(2'b01, 20, 7);
      issue(2'b10, 31, 31);
      issue(2'b10, 6, 0);
      issue(2'b10, 0, 17);
      issue(2'b11, 5, 5);
      issue(2'b00, 1, 1);

      // start during MUL step 2 must be ignored
      issue(2'b10, 23, 19);
      repeat (2) @(negedge clk);
      start = 1'b1; op = 2'b00; a = 5'd1; b = 5'd1;
      @(negedge clk);
      start = 1'b0;
      issue(2'b00, 31, 31);

      // reset in the middle of a multiply
      issue(2'b10, 29, 27);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_result", int'(result), 0);
      chk("midrst_carry", int'(carry), 0);
      chk("midrst_err", int'(err), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(2'b00, 3, 4);

      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      end

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
